// File: rtl/fp_normalizer.sv
// FP adder back end: normalizes the raw mantissa one bit per cycle and packs a single-precision word.
// Optional status flags (overflow/underflow/zero) are built when NORM_STATUS_EN is defined.
module fp_normalizer #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exponent,
   input  logic [MANT_W+1:0]       in_mantissa,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+MANT_W:0]   result
`ifdef NORM_STATUS_EN
   ,
   output logic                    flag_overflow,
   output logic                    flag_underflow,
   output logic                    flag_zero
`endif
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

   state_t                   state, state_nx;
   logic                     sign_q;
   logic [EXP_W:0]           exp_q, exp_nx, exp_inc;
   logic [MANT_W+1:0]        mant_q, mant_nx;
   logic [EXP_W+MANT_W:0]    result_nx;
   logic                     load_result;
   logic                     ovf_nx, unf_nx;

   assign exp_inc = exp_q + EXP_ONE;

   always_comb begin
      state_nx    = state;
      exp_nx      = exp_q;
      mant_nx     = mant_q;
      result_nx   = '0;
      load_result = 1'b0;
      ovf_nx      = 1'b0;
      unf_nx      = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               exp_nx   = {1'b0, in_exponent};
               mant_nx  = in_mantissa;
               state_nx = NORM;
            end
         end
         NORM: begin
            if (exp_q == EXP_MAX) begin
               result_nx   = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
               load_result = 1'b1;
               state_nx    = DONE;
            end else if (mant_q == '0 || exp_q == '0) begin
               result_nx   = {sign_q, {(EXP_W+MANT_W){1'b0}}};
               unf_nx      = (exp_q == '0) && (mant_q != '0);
               load_result = 1'b1;
               state_nx    = DONE;
            end else if (mant_q[MANT_W+1]) begin
               // Carry: one right shift always lands the hidden bit, so pack directly.
               mant_nx     = mant_q >> 1;
               exp_nx      = exp_inc;
               load_result = 1'b1;
               state_nx    = DONE;
               if (exp_inc == EXP_MAX) begin
                  result_nx = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                  ovf_nx    = 1'b1;
               end else begin
                  result_nx = {sign_q, exp_inc[EXP_W-1:0], mant_q[MANT_W:1]};
               end
            end else if (mant_q[MANT_W]) begin
               result_nx   = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
               load_result = 1'b1;
               state_nx    = DONE;
            end else if (exp_q == EXP_ONE) begin
               result_nx   = {sign_q, {(EXP_W+MANT_W){1'b0}}};
               unf_nx      = 1'b1;
               load_result = 1'b1;
               state_nx    = DONE;
            end else begin
               mant_nx = mant_q << 1;
               exp_nx  = exp_q - EXP_ONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         sign_q <= 1'b0;
         exp_q  <= '0;
         mant_q <= '0;
         result <= '0;
      end else begin
         state  <= state_nx;
         exp_q  <= exp_nx;
         mant_q <= mant_nx;
         if (state == IDLE && in_valid) sign_q <= in_sign;
         if (load_result) result <= result_nx;
      end
   end

`ifdef NORM_STATUS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_zero      <= 1'b0;
      end else if (load_result) begin
         flag_overflow  <= ovf_nx;
         flag_underflow <= unf_nx;
         flag_zero      <= (result_nx[EXP_W+MANT_W-1:0] == '0);
      end else if (state == DONE && out_ready) begin
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_zero      <= 1'b0;
      end
   end
`else
   logic unused_flags;
   assign unused_flags = ovf_nx ^ unf_nx;
`endif

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer: result packing, latency, boundaries, backpressure and mid-op reset.
module tb_fp_normalizer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exponent;
   logic [24:0] in_mantissa;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
`ifdef NORM_STATUS_EN
   logic        flag_overflow, flag_underflow, flag_zero;
`endif

   int checks = 0;
   int passed = 0;
   int failed = 0;

   fp_normalizer #(.EXP_W(8), .MANT_W(23)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sign     (in_sign),
      .in_exponent (in_exponent),
      .in_mantissa (in_mantissa),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result)
`ifdef NORM_STATUS_EN
      ,
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .flag_zero      (flag_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one operand, measure cycles from accept to out_valid, check result and flags.
   task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                         input int exp_lat, input logic [31:0] exp_res, input logic [2:0] exp_flags);
      int lat;
      @(negedge clk);
      in_valid    = 1'b1;
      in_sign     = s;
      in_exponent = e;
      in_mantissa = m;
      #1;
      check({tag, ".in_ready"}, {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".latency"}, lat, exp_lat);
      check({tag, ".result"}, result, exp_res);
`ifdef NORM_STATUS_EN
      check({tag, ".flags"}, {29'h0, flag_overflow, flag_underflow, flag_zero}, {29'h0, exp_flags});
`else
      if (exp_flags === 3'bxxx) $display("unexpected flag vector");
`endif
      @(posedge clk);
      #1;
      check({tag, ".out_valid_drop"}, {31'h0, out_valid}, 32'h0);
      check({tag, ".in_ready_back"}, {31'h0, in_ready}, 32'h1);
   endtask

   initial begin
      int lat;
      logic [31:0] held;
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_sign     = 1'b0;
      in_exponent = 8'h00;
      in_mantissa = 25'h0;
      out_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", {31'h0, out_valid}, 32'h0);
      check("rst.in_ready", {31'h0, in_ready}, 32'h1);
      check("rst.result", result, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op("norm",      1'b0, 8'h7F, 25'h0800000, 2,  32'h3F800000, 3'b000);
      run_op("carry",     1'b0, 8'h7F, 25'h1000000, 2,  32'h40000000, 3'b000);
      run_op("cancel",    1'b0, 8'h80, 25'h0200000, 4,  32'h3F000000, 3'b000);
      run_op("zero",      1'b1, 8'h7F, 25'h0000000, 2,  32'h80000000, 3'b001);
      run_op("overflow",  1'b0, 8'hFE, 25'h1000000, 2,  32'h7F800000, 3'b100);
      run_op("underflow", 1'b0, 8'h02, 25'h0000001, 3,  32'h00000000, 3'b011);
      run_op("passthru",  1'b1, 8'hFF, 25'h0123456, 2,  32'hFF923456, 3'b000);
      run_op("exp0",      1'b0, 8'h00, 25'h0800000, 2,  32'h00000000, 3'b011);
      run_op("maxshift",  1'b0, 8'h7F, 25'h0000001, 25, 32'h34000000, 3'b000);
      run_op("carryfrac", 1'b1, 8'h80, 25'h1800001, 2,  32'hC0C00000, 3'b000);
      run_op("negfrac",   1'b1, 8'h85, 25'h0ABCDEF, 2,  32'hC2ABCDEF, 3'b000);

      // Backpressure: result must hold and no new operand may be taken while DONE.
      @(negedge clk);
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      in_sign     = 1'b0;
      in_exponent = 8'h7F;
      in_mantissa = 25'h1000000;
      @(posedge clk);
      #1;
      in_exponent = 8'h10;
      in_mantissa = 25'h0800000;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp.latency", lat, 2);
      held = result;
      check("bp.result", held, 32'h40000000);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp.hold_result", result, 32'h40000000);
         check("bp.hold_valid", {31'h0, out_valid}, 32'h1);
         check("bp.hold_in_ready", {31'h0, in_ready}, 32'h0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(posedge clk);
      #1;
      check("bp.release_valid", {31'h0, out_valid}, 32'h0);
      check("bp.release_in_ready", {31'h0, in_ready}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("bp.no_extra_valid", {31'h0, out_valid}, 32'h0);

      // Reset during a 10-bit left shift.
      @(negedge clk);
      in_valid    = 1'b1;
      in_sign     = 1'b1;
      in_exponent = 8'h7F;
      in_mantissa = 25'h0002000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst.out_valid", {31'h0, out_valid}, 32'h0);
      check("midrst.in_ready", {31'h0, in_ready}, 32'h1);
      check("midrst.result", result, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("midrst.no_result", {31'h0, out_valid}, 32'h0);
      run_op("post_rst", 1'b0, 8'h7F, 25'h0800000, 2, 32'h3F800000, 3'b000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
- Back end of the FP adder datapath. Accepts the raw mantissa sum/difference with its carry bit, the common exponent and the result sign from the add stage.
- Normalizes the mantissa over multiple cycles, one bit of shift per cycle, and packs an IEEE-754 single-precision word.
- Valid/ready handshake on both input and output.
- Rounding is truncation, consistent with the truncating alignment shift upstream.

Parameters:
- EXP_W, 8, exponent width
- MANT_W, 23, stored fraction width; the internal sum is MANT_W+2 bits (carry + hidden + fraction)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand present
- in_ready  out  1  block can accept
- in_sign  in  1  result sign
- in_exponent  in  EXP_W  common (larger) exponent from alignment
- in_mantissa  in  MANT_W+2  bit24 = carry, bit23 = hidden position
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- result  out  32  packed {sign, exponent, fraction}

Behaviour:
- Reset values (reset_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, result=32'h0, internal registers 0.
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, NORM, DONE.
- IDLE
  - in_ready=1.
  - When in_valid=1, capture sign, exponent and mantissa, then go to NORM.
- NORM (in_ready=0). Evaluated once per cycle, first match wins:
  - exp==8'hFF: pass through as {sign, 8'hFF, mant[22:0]} -> DONE.
  - mant==0 or exp==0: zero result {sign, 31'h0} -> DONE.
  - mant[24]==1: mant>>=1, exp+=1. If the new exp==8'hFF, result is infinity {sign, 8'hFF, 23'h0}; overflow. -> DONE.
  - mant[23]==1: pack {sign, exp, mant[22:0]} -> DONE.
  - exp==1: flush to {sign, 31'h0}; underflow. -> DONE.
  - Otherwise: mant<<=1, exp-=1, stay in NORM.
- DONE
  - out_valid=1; result is stable until the handshake.
  - When out_ready=1, clear out_valid and go to IDLE.
  - in_ready=0 throughout, so no new operand is accepted until the result is consumed. Next accept is at the earliest one cycle after the out handshake.
- Latency: accept at cycle N. out_valid rises at N+2 for already-normalized or carry inputs, and at N+2+k for a left shift of k bits.
- Maximum left shift is 23, so worst-case latency is 25 cycles.
- Widths: exponent arithmetic is done in EXP_W+1 bits internally. Exponent never wraps below 1 or above 8'hFF.

Optional Feature:
- Macro: NORM_STATUS_EN.
- Defined: adds three output ports, each 1 bit, all reset to 0:
  - flag_overflow: result is infinity from a carry.
  - flag_underflow: flush-to-zero from exp==1 or exp==0 with non-zero mantissa.
  - flag_zero: result exponent and fraction are 0.
  - Flags are valid with out_valid and are cleared on the out handshake.
- Undefined: these ports and their logic are absent. Datapath behaviour is identical.

Test Plan:
- Normalized input: sign=0, exp=8'h7F, mant=25'h0800000, out_ready=1 -> result=32'h3F800000; out_valid exactly 2 cycles after accept.
- Carry input: exp=8'h7F, mant=25'h1000000 -> result=32'h40000000 (2.0), 2-cycle latency.
- Cancellation: exp=8'h80, mant=25'h0200000 -> 2 left shifts -> result=32'h3F000000, 4-cycle latency.
- Boundaries:
  - sign=1, mant=0 -> 32'h80000000, flag_zero.
  - exp=8'hFE, mant=25'h1000000 -> 32'h7F800000, flag_overflow.
  - exp=8'h02, mant=25'h0000001 -> 32'h00000000, flag_underflow.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result unchanged and in_ready=0 throughout. Raise out_ready -> out_valid drops next cycle, in_ready returns.
- Reset mid-op: assert reset_n=0 during a 10-bit left-shift operation -> outputs reset immediately. After release, a new operand exp=8'h7F, mant=25'h0800000 yields 32'h3F800000.
